// File: rtl/dm_mem_responder.sv
// dm_mem_responder -- line-granular main-memory model for the cache FSM.
//
// Holds 2^LINE_AW lines of 128 bits, accepts one read or write-back at a
// time and acknowledges each one LATENCY cycles after acceptance with a
// single-cycle ready pulse. Write-backs commit on the acceptance edge.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous reset, active low
//   mem_req   in   mem_req_type  {addr, data, rw, valid}; rw=1 write-back
//   mem_data  out  mem_data_type {data, ready}; data is 0 unless ready
//   rd_count  out  completed reads  (0 unless MEM_STATS_EN)
//   wr_count  out  completed writes (0 unless MEM_STATS_EN)
//
// Optional feature: define MEM_STATS_EN to build the read/write counters.
//
// The array is preloaded at time zero with word k of line L holding
// (L<<4)|(k<<2). Reset leaves the array untouched.

package dm_mem_responder_pkg;
    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
        logic         rw;
        logic         valid;
    } mem_req_type;

    typedef struct packed {
        logic [127:0] data;
        logic         ready;
    } mem_data_type;
endpackage

// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for mem_req.valid
// BUSY    | request accepted, latency counter running, mem_req ignored
// RESPOND | ready high this cycle; may accept the next request
module dm_mem_responder
    import dm_mem_responder_pkg::*;
#(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned LINE_AW = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  mem_req_type  mem_req,
    output mem_data_type mem_data,
    output logic [31:0]  rd_count,
    output logic [31:0]  wr_count
);

    localparam int unsigned NUM_LINES = 1 << LINE_AW;
    localparam logic [7:0]  LAT_M1    = 8'(LATENCY - 1);

    typedef logic [127:0] line_t;
    typedef line_t mem_array_t [NUM_LINES];

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    function automatic mem_array_t init_lines();
        mem_array_t a;
        for (int l = 0; l < NUM_LINES; l++) begin
            for (int k = 0; k < 4; k++) begin
                a[l][k*32 +: 32] = 32'((l << 4) | (k << 2));
            end
        end
        return a;
    endfunction

    mem_array_t lines = init_lines();

    state_t               state;
    logic [7:0]           cnt;
    logic [LINE_AW-1:0]   idx;
    logic                 rw_q;
    logic [LINE_AW-1:0]   req_idx;
    logic                 accept;

    assign req_idx = mem_req.addr[LINE_AW+3:4];

    // A request is taken in IDLE or in the RESPOND cycle (back-to-back
    // handoff); a same-edge reset blocks it.
    assign accept = rst && mem_req.valid && (state == IDLE || state == RESPOND);

    // Offset and alias bits of the address are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_req.addr[31:LINE_AW+4], mem_req.addr[3:0]};

    // Write commit happens on the acceptance edge, independent of reset so
    // that an accepted write survives an abort.
    always_ff @(posedge clk) begin
        if (accept && mem_req.rw) begin
            lines[req_idx] <= mem_req.data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            rw_q          <= 1'b0;
            mem_data.ready <= 1'b0;
            mem_data.data  <= '0;
        end else begin
            case (state)
                IDLE, RESPOND: begin
                    if (mem_req.valid) begin
                        idx  <= req_idx;
                        rw_q <= mem_req.rw;
                        cnt  <= LAT_M1;
                        if (LATENCY == 1) begin
                            // The acceptance cycle is also the cycle before
                            // RESPOND, so read straight from the request index.
                            state          <= RESPOND;
                            mem_data.ready <= 1'b1;
                            mem_data.data  <= mem_req.rw ? '0 : lines[req_idx];
                        end else begin
                            state          <= BUSY;
                            mem_data.ready <= 1'b0;
                            mem_data.data  <= '0;
                        end
                    end else begin
                        state          <= IDLE;
                        mem_data.ready <= 1'b0;
                        mem_data.data  <= '0;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 8'd1;
                    // The edge that takes the counter to 0 enters RESPOND.
                    if (cnt <= 8'd1) begin
                        state          <= RESPOND;
                        mem_data.ready <= 1'b1;
                        mem_data.data  <= rw_q ? '0 : lines[idx];
                    end
                end
                default: begin
                    state          <= IDLE;
                    mem_data.ready <= 1'b0;
                    mem_data.data  <= '0;
                end
            endcase
        end
    end

`ifdef MEM_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (state == RESPOND) begin
            if (rw_q) begin
                wr_count <= wr_count + 32'd1;
            end else begin
                rd_count <= rd_count + 32'd1;
            end
        end
    end
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule

// File: tb/tb_dm_mem_responder.sv
module tb_dm_mem_responder;
    import dm_mem_responder_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    mem_req_type  req [2];
    mem_data_type rsp [2];
    logic [31:0]  rd_cnt [2];
    logic [31:0]  wr_cnt [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dm_mem_responder #(.LATENCY(4), .LINE_AW(12)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .mem_req  (req[0]),
        .mem_data (rsp[0]),
        .rd_count (rd_cnt[0]),
        .wr_count (wr_cnt[0])
    );

    dm_mem_responder #(.LATENCY(1), .LINE_AW(12)) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .mem_req  (req[1]),
        .mem_data (rsp[1]),
        .rd_count (rd_cnt[1]),
        .wr_count (wr_cnt[1])
    );

    typedef struct {
        logic [31:0]  addr;
        logic         rw;
        logic [127:0] wdata;
        logic [127:0] exp;
    } vec_t;

    localparam logic [127:0] W1 = 128'hDEADBEEF_CAFEF00D_12345678_00000001;
    localparam logic [127:0] W2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] W3 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    localparam logic [127:0] W4 = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] W5 = 128'h55555555_66666666_77777777_88888888;
    localparam logic [127:0] W6 = 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC;

    // Preloaded content for the line an address maps to (index = addr[15:4]).
    function automatic logic [127:0] init_line(input logic [31:0] a);
        logic [31:0] b;
        b = a & 32'h0000_FFF0;
        return {b | 32'hC, b | 32'h8, b | 32'h4, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input int d, output int n);
        n = 1;
        while (!rsp[d].ready && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic run_txn(input int d, input string name, input logic [31:0] addr,
                           input logic rw, input logic [127:0] wdata,
                           input logic [127:0] exp, input int lat);
        int n;
        req[d] = '{addr: addr, data: wdata, rw: rw, valid: 1'b1};
        tick();
        req[d].valid = 1'b0;
        wait_ready(d, n);
        chk({name, " latency"}, 128'(n), 128'(lat));
        chk({name, " data"}, rsp[d].data, exp);
        tick();
        chk({name, " ready drop"}, 128'(rsp[d].ready), 128'd0);
        chk({name, " data idle"}, rsp[d].data, 128'd0);
    endtask

    task automatic no_ready(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (rsp[0].ready) seen++;
        end
        chk(name, 128'(seen), 128'd0);
    endtask

    vec_t vecs [8];

    initial begin
        int n;
        logic [31:0] exp_rd, exp_wr;

        vecs[0] = '{32'h0000_0120, 1'b0, '0, {32'h12C, 32'h128, 32'h124, 32'h120}};
        vecs[1] = '{32'h0000_0340, 1'b1, W1, '0};
        vecs[2] = '{32'h0000_0348, 1'b0, '0, W1};
        vecs[3] = '{32'h0001_0340, 1'b0, '0, W1};
        vecs[4] = '{32'h0000_7FF0, 1'b1, W2, '0};
        vecs[5] = '{32'hFFFF_7FF5, 1'b0, '0, W2};
        vecs[6] = '{32'h0000_FFF0, 1'b0, '0, init_line(32'h0000_FFF0)};
        vecs[7] = '{32'h0000_0000, 1'b0, '0, {32'hC, 32'h8, 32'h4, 32'h0}};

        rst    = 1'b0;
        req[0] = '0;
        req[1] = '0;
        repeat (3) tick();
        chk("reset ready", 128'(rsp[0].ready), 128'd0);
        chk("reset data", rsp[0].data, 128'd0);
        chk("reset rd_count", 128'(rd_cnt[0]), 128'd0);
        chk("reset wr_count", 128'(wr_cnt[0]), 128'd0);
        chk("reset ready lat1", 128'(rsp[1].ready), 128'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_txn(0, $sformatf("vec%0d", i), vecs[i].addr, vecs[i].rw,
                    vecs[i].wdata, vecs[i].exp, 4);
        end

        // Back-to-back: write-back then a read issued inside its RESPOND cycle.
        req[0] = '{addr: 32'h0000_0500, data: W3, rw: 1'b1, valid: 1'b1};
        tick();
        req[0].valid = 1'b0;
        wait_ready(0, n);
        chk("b2b wr latency", 128'(n), 128'd4);
        chk("b2b wr ack data", rsp[0].data, 128'd0);
        req[0] = '{addr: 32'h0000_1000, data: '0, rw: 1'b0, valid: 1'b1};
        tick();
        req[0].valid = 1'b0;
        chk("b2b gap ready", 128'(rsp[0].ready), 128'd0);
        wait_ready(0, n);
        chk("b2b rd latency", 128'(n), 128'd4);
        chk("b2b rd data", rsp[0].data, {32'h100C, 32'h1008, 32'h1004, 32'h1000});
        tick();
        chk("b2b rd drop", 128'(rsp[0].ready), 128'd0);
        run_txn(0, "b2b wr readback", 32'h0000_0500, 1'b0, '0, W3, 4);

        // Busy ignore: a would-be write toggles on valid during BUSY.
        req[0] = '{addr: 32'h0000_0120, data: '0, rw: 1'b0, valid: 1'b1};
        tick();
        req[0] = '{addr: 32'h0000_05A0, data: W6, rw: 1'b1, valid: 1'b1};
        tick();
        req[0].valid = 1'b0;
        tick();
        req[0].valid = 1'b1;
        tick();
        req[0].valid = 1'b0;
        chk("busy ready", 128'(rsp[0].ready), 128'd1);
        chk("busy data", rsp[0].data, init_line(32'h0000_0120));
        no_ready("busy extra pulses", 6);
        run_txn(0, "busy no write", 32'h0000_05A0, 1'b0, '0, init_line(32'h0000_05A0), 4);

        // Reset two cycles into a read: aborted, no ready.
        req[0] = '{addr: 32'h0000_0120, data: '0, rw: 1'b0, valid: 1'b1};
        tick();
        req[0].valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("abort ready", 128'(rsp[0].ready), 128'd0);
        no_ready("abort no ready", 6);

        // Reset mid write-back: the write still commits.
        req[0] = '{addr: 32'h0000_0260, data: W4, rw: 1'b1, valid: 1'b1};
        tick();
        req[0].valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("abort wr ready", 128'(rsp[0].ready), 128'd0);
        run_txn(0, "abort wr readback", 32'h0000_0260, 1'b0, '0, W4, 4);

        // Reset and valid on the same edge: request is dropped.
        rst    = 1'b0;
        req[0] = '{addr: 32'h0000_0120, data: '0, rw: 1'b0, valid: 1'b1};
        tick();
        rst          = 1'b1;
        req[0].valid = 1'b0;
        no_ready("rst+valid dropped", 6);

        // LATENCY=1 instance, also exercises the statistics counters.
        run_txn(1, "l1 wr0", 32'h0000_0340, 1'b1, W5, '0, 1);
        run_txn(1, "l1 rd0", 32'h0000_0340, 1'b0, '0, W5, 1);
        run_txn(1, "l1 rd1", 32'h0000_0120, 1'b0, '0, init_line(32'h0000_0120), 1);
        run_txn(1, "l1 wr1", 32'h0000_0900, 1'b1, W6, '0, 1);
        run_txn(1, "l1 rd2", 32'h0000_0904, 1'b0, '0, W6, 1);
`ifdef MEM_STATS_EN
        exp_rd = 32'd3;
        exp_wr = 32'd2;
`else
        exp_rd = 32'd0;
        exp_wr = 32'd0;
`endif
        chk("stats rd_count", 128'(rd_cnt[1]), 128'(exp_rd));
        chk("stats wr_count", 128'(wr_cnt[1]), 128'(exp_wr));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dm_mem_responder.md
# dm_mem_responder

Line-granular main-memory model that answers the cache FSM's memory requests (`mem_req_type` in, `mem_data_type` out). It sits on the memory side of the cache–memory interface and replaces the ideal memory in cache benches. It stores 128-bit lines, accepts one read or write-back at a time, and acknowledges each request after a fixed, parameterised latency.

## Interface
- `LATENCY`, default 4: cycles from request acceptance to the `ready` pulse; legal range 1..255.
- `LINE_AW`, default 12: line-index width; the array holds 2^LINE_AW lines of 128 bits, indexed by `addr[LINE_AW+3:4]`.
- `clk`  in  1: clock; all state changes on its rising edge.
- `rst`  in  1: reset, synchronous, active-low.
- `mem_req`  in  `mem_req_type` (addr 32, data 128, rw 1, valid 1): request from the cache. `rw`=1 is a write-back, `rw`=0 is a line read.
- `mem_data`  out  `mem_data_type` (data 128, ready 1): response to the cache.
- `rd_count`  out  32: completed reads (only under `MEM_STATS_EN`).
- `wr_count`  out  32: completed writes (only under `MEM_STATS_EN`).

## Operation
- States: IDLE, BUSY, RESPOND.
- **IDLE:** if `mem_req.valid`=1, accept the request.
  - Latch `addr[LINE_AW+3:4]` and `rw`.
  - Load the down-counter with `LATENCY-1`.
  - If `LATENCY`=1, go to RESPOND; otherwise go to BUSY.
- **Write commit:** a write stores `mem_req.data` into the array on the acceptance edge, so any later read of the same line returns the new data.
- **BUSY:** decrement the counter each cycle. When the counter reaches 0, go to RESPOND. `mem_req` is ignored in BUSY.
- **RESPOND:** `mem_data.ready`=1 for exactly this cycle.
  - For a read, `mem_data.data` = the latched line.
  - For a write, `mem_data.data` = 0.
  - If `mem_req.valid`=1 in this cycle, accept it as a new request (same actions as IDLE). This supports the write_back→allocate back-to-back handoff.
  - Otherwise go to IDLE.
- **Address bits:** `addr[3:0]` and `addr[31:LINE_AW+4]` are ignored. Addresses alias modulo the array size.
- **Initial contents:** each word k of line L = byte address `(L<<4)|(k<<2)`, zero-extended to 32 bits. This is loaded at time zero. Reset does not clear the array.
- **Handshake contract:** the cache holds `valid` for at least the acceptance cycle, and deasserts `valid` in RESPOND unless it is issuing its next request. A `valid` that stays high after RESPOND is a new request.

## Timing
- Acceptance on rising edge t → `ready` high during cycle t+LATENCY, for one cycle only.
- `mem_data.data` is registered. It is driven from the array one cycle before RESPOND (from the latched index) and is 0 whenever `ready`=0.
- Back-to-back: a request accepted in RESPOND at edge t' produces the next `ready` at t'+LATENCY. No idle bubble is required.
- Reset values: state IDLE, `mem_data.ready`=0, `mem_data.data`=0, counter 0, `rd_count`=`wr_count`=0.
- Reset mid-operation: the transaction is aborted and no `ready` is issued. A write already accepted stays committed.
- `rst` and `valid` high on the same edge: reset wins and the request is not accepted.

## Configuration
- `MEM_STATS_EN` defined:
  - `rd_count` increments on each read RESPOND cycle.
  - `wr_count` increments on each write RESPOND cycle.
  - Both counters wrap at 2^32 and clear on reset.
- `MEM_STATS_EN` undefined: the counters are not built and both outputs are tied to 0.

## Test plan
- **Read latency:** reset, then read `addr`=0x0000_0120 with `LATENCY`=4 → `ready` exactly 4 cycles after the accept edge, for one cycle; data = {0x12C, 0x128, 0x124, 0x120}.
- **Write then read:** write line 0x0000_0340 with data 0xDEADBEEF_…_0000_0001, wait for `ready`, then read 0x0000_0348 → same 128-bit line returned; write-ack data = 0.
- **Back-to-back handoff:** write-back accepted, and in its RESPOND cycle drive `valid`=1, `rw`=0, `addr`=0x0000_1000 → second `ready` exactly `LATENCY` cycles later, with no gap state.
- **Busy ignore:** toggle `valid` with a different address during BUSY → no extra `ready` pulses; the response matches the first request.
- **Reset mid-op:** drive `rst`=0 two cycles after a read is accepted → `ready` never asserts and the block is IDLE on the next cycle; a write accepted before reset is readable afterwards.
- **Stats / LATENCY=1 (with `MEM_STATS_EN`):** 3 reads and 2 writes → `rd_count`=3, `wr_count`=2. With `LATENCY`=1, `ready` asserts the cycle after acceptance.
